// File: rtl/mem_stage_if.sv
// Pipeline bus between AGEX, MEM and the forwarding network.
// Carries the AGEX latch contents into the memory stage and brings the MEM
// latch and the combinational forwarding path back out of it.
interface mem_stage_if #(
    parameter int unsigned DBITS = 32
);
    // AGEX latch contents
    logic             agex_valid;
    logic             agex_is_load;
    logic             agex_is_store;
    logic [2:0]       agex_funct3;
    logic [DBITS-1:0] agex_result;
    logic [DBITS-1:0] agex_st_data;
    logic             agex_wr_reg;
    logic [4:0]       agex_rd;
    logic [DBITS-1:0] agex_pc;
    logic [DBITS-1:0] agex_inst_count;

    // MEM latch contents for WB
    logic             mem_valid;
    logic             mem_wr_reg;
    logic [4:0]       mem_rd;
    logic [DBITS-1:0] mem_wb_data;
    logic [DBITS-1:0] mem_pc;
    logic [DBITS-1:0] mem_inst_count;

    // Same-cycle forwarding back to DE
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [DBITS-1:0] fwd_data;

    // Upstream side: presents an instruction, observes the stage outputs.
    modport master (
        output agex_valid, agex_is_load, agex_is_store, agex_funct3,
               agex_result, agex_st_data, agex_wr_reg, agex_rd,
               agex_pc, agex_inst_count,
        input  mem_valid, mem_wr_reg, mem_rd, mem_wb_data, mem_pc,
               mem_inst_count, fwd_valid, fwd_rd, fwd_data
    );

    // The memory stage itself.
    modport slave (
        input  agex_valid, agex_is_load, agex_is_store, agex_funct3,
               agex_result, agex_st_data, agex_wr_reg, agex_rd,
               agex_pc, agex_inst_count,
        output mem_valid, mem_wr_reg, mem_rd, mem_wb_data, mem_pc,
               mem_inst_count, fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RV32 pipeline.
// Performs byte/half/word loads and stores against a word-organised data
// memory (combinational read, byte-lane write) and a memory-mapped LED
// register, registers the result into the MEM latch for WB and drives the
// same-cycle forwarding path back to DE. Misaligned accesses are squashed
// (no side effects, no register write) and raise a sticky error flag.
module mem_stage #(
    parameter int unsigned DBITS          = 32,
    parameter int unsigned DMEM_ADDR_BITS = 12,
    parameter logic [DBITS-1:0] MMIO_BASE = 32'hFFFFF000,
    parameter logic [DBITS-1:0] LED_ADDR  = 32'hFFFFF020,
    parameter int unsigned LED_BITS       = 10
) (
    input  logic                clk,
    input  logic                reset,
    mem_stage_if.slave          bus,
    output logic [LED_BITS-1:0] led,
    output logic                misalign_err,
    output logic [31:0]         load_count,
    output logic [31:0]         store_count
);

    localparam int unsigned DMEM_DEPTH = 1 << DMEM_ADDR_BITS;
    localparam int unsigned NUM_LANES  = DBITS / 8;

    // Access size encoded in funct3[1:0]; funct3[2] selects zero-extension.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [DBITS-1:0]          addr;
    size_e                     size;
    logic                      is_unsigned;
    logic                      is_mmio;
    logic                      is_led;
    logic                      is_access;
    logic                      misaligned_addr;
    logic                      misaligned;
    logic [DMEM_ADDR_BITS-1:0] word_idx;

    assign addr        = bus.agex_result;
    assign size        = size_e'(bus.agex_funct3[1:0]);
    assign is_unsigned = bus.agex_funct3[2];
    assign is_mmio     = (addr >= MMIO_BASE);
    assign is_led      = (addr == LED_ADDR);
    assign is_access   = bus.agex_is_load | bus.agex_is_store;
    // Upper address bits above the DMEM window alias onto the same words.
    assign word_idx    = addr[DMEM_ADDR_BITS+1:2];

    // Alignment check by access size; reserved sizes are treated as words.
    // NOTE: every signal driven from always_comb gets a default first, so a
    // missed branch can never hold an old value and infer a latch.
    always_comb begin
        misaligned_addr = 1'b0;
        case (size)
            SZ_BYTE: misaligned_addr = 1'b0;
            SZ_HALF: misaligned_addr = addr[0];
            default: misaligned_addr = (addr[1:0] != 2'b00);
        endcase
    end

    assign misaligned = bus.agex_valid & is_access & misaligned_addr;

    // Qualified side-effect strobes; reset blocks every architectural write.
    logic do_load;
    logic do_store;
    logic dmem_we;
    logic led_we;

    assign do_load  = bus.agex_valid & bus.agex_is_load  & ~misaligned & ~reset;
    assign do_store = bus.agex_valid & bus.agex_is_store & ~misaligned & ~reset;
    assign dmem_we  = do_store & ~is_mmio;
    assign led_we   = do_store & is_mmio & is_led;

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [DBITS-1:0]     dmem [DMEM_DEPTH];
    logic [DBITS-1:0]     rd_word;
    logic [NUM_LANES-1:0] st_be;
    logic [DBITS-1:0]     st_wdata;

    assign rd_word = dmem[word_idx];

    // Replicate store data onto every lane and enable only the addressed lanes.
    always_comb begin
        st_be    = '0;
        st_wdata = bus.agex_st_data;
        case (size)
            SZ_BYTE: begin
                st_be    = NUM_LANES'(1) << addr[1:0];
                st_wdata = {NUM_LANES{bus.agex_st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = addr[1] ? NUM_LANES'(4'b1100) : NUM_LANES'(4'b0011);
                st_wdata = {(NUM_LANES/2){bus.agex_st_data[15:0]}};
            end
            default: begin
                st_be    = '1;
                st_wdata = bus.agex_st_data;
            end
        endcase
    end

    // Byte-lane write port; untouched lanes keep their contents.
    // NOTE: the memory array has no reset on purpose -- clearing thousands of
    // words would prevent mapping it onto block RAM, and software never relies
    // on its power-up contents.
    always_ff @(posedge clk) begin
        if (dmem_we) begin
            for (int lane = 0; lane < NUM_LANES; lane++) begin
                if (st_be[lane]) begin
                    dmem[word_idx][lane*8 +: 8] <= st_wdata[lane*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and writeback value
    // ------------------------------------------------------------------
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [DBITS-1:0] dmem_load;
    logic [DBITS-1:0] load_data;
    logic [DBITS-1:0] wb_value;

    assign lane_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    assign lane_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

    // Select the addressed byte/half and extend it by funct3.
    always_comb begin
        dmem_load = rd_word;
        case (size)
            SZ_BYTE: dmem_load = {{(DBITS-8){lane_byte[7] & ~is_unsigned}}, lane_byte};
            SZ_HALF: dmem_load = {{(DBITS-16){lane_half[15] & ~is_unsigned}}, lane_half};
            default: dmem_load = rd_word;
        endcase
    end

    // MMIO loads ignore size: LED reads back zero-extended, holes read as 0.
    always_comb begin
        load_data = dmem_load;
        if (is_mmio) begin
            load_data = is_led ? DBITS'(led) : '0;
        end
    end

    assign wb_value = bus.agex_is_load ? load_data : bus.agex_result;

    // ------------------------------------------------------------------
    // Forwarding path
    // ------------------------------------------------------------------
    // Stores never write rd, even if the decoder left wr_reg set.
    assign bus.fwd_valid = bus.agex_valid & bus.agex_wr_reg & ~bus.agex_is_store &
                           (bus.agex_rd != 5'd0) & ~misaligned & ~reset;
    assign bus.fwd_rd    = bus.agex_rd;
    assign bus.fwd_data  = wb_value;

    // ------------------------------------------------------------------
    // MEM latch
    // ------------------------------------------------------------------
    // Load the MEM latch every cycle; bubbles propagate as valid=0, wr_reg=0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_valid      <= 1'b0;
            bus.mem_wr_reg     <= 1'b0;
            bus.mem_rd         <= '0;
            bus.mem_wb_data    <= '0;
            bus.mem_pc         <= '0;
            bus.mem_inst_count <= '0;
        end else begin
            bus.mem_valid      <= bus.agex_valid;
            bus.mem_wr_reg     <= bus.fwd_valid;
            bus.mem_rd         <= bus.agex_rd;
            bus.mem_wb_data    <= wb_value;
            bus.mem_pc         <= bus.agex_pc;
            bus.mem_inst_count <= bus.agex_inst_count;
        end
    end

    // ------------------------------------------------------------------
    // MMIO register, error flag and retirement counters
    // ------------------------------------------------------------------
    // LED register captures the low bits of any aligned store to its address.
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else if (led_we) begin
            led <= bus.agex_st_data[LED_BITS-1:0];
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (misaligned) begin
            misalign_err <= 1'b1;
        end
    end

    // Count retired aligned loads and stores (MMIO included), wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_count  <= '0;
            store_count <= '0;
        end else begin
            if (do_load) begin
                load_count <= load_count + 32'd1;
            end
            if (do_store) begin
                store_count <= store_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed instruction stream with hand-computed
// results. The driver pushes each instruction's expected MEM-latch contents
// into a queue; a negedge monitor pops and compares once the latch has taken it.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  led;
    logic        misalign_err;
    logic [31:0] load_count;
    logic [31:0] store_count;

    always #5 clk = ~clk;

    mem_stage_if #(.DBITS(32)) bus ();

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .led          (led),
        .misalign_err (misalign_err),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    typedef struct {
        int unsigned cyc;
        logic        valid;
        logic        wr;
        logic [4:0]  rd;
        logic        chk_wb;
        logic [31:0] wb;
        logic [31:0] pc;
        logic [31:0] ic;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        n_tests++;
        if (act === bad) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h which must differ from 0x%08h", name, act, bad);
        end
    endtask

    // Present one instruction, queue its expected MEM latch, check forwarding.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic wr, input logic [4:0] rd,
                         input logic exp_wr, input logic chk_wb, input logic [31:0] exp_wb);
        exp_t e;
        @(posedge clk);
        #1;
        bus.agex_valid      = 1'b1;
        bus.agex_is_load    = ld;
        bus.agex_is_store   = st;
        bus.agex_funct3     = f3;
        bus.agex_result     = res;
        bus.agex_st_data    = sd;
        bus.agex_wr_reg     = wr;
        bus.agex_rd         = rd;
        bus.agex_pc         = pc_ctr;
        bus.agex_inst_count = pc_ctr >> 2;
        e.cyc    = cyc;
        e.valid  = 1'b1;
        e.wr     = exp_wr;
        e.rd     = rd;
        e.chk_wb = chk_wb;
        e.wb     = exp_wb;
        e.pc     = pc_ctr;
        e.ic     = pc_ctr >> 2;
        sb_q.push_back(e);
        pc_ctr += 32'd4;
        #1;
        check("fwd_valid", 32'(bus.fwd_valid), 32'(exp_wr));
        if (exp_wr) begin
            check("fwd_rd", 32'(bus.fwd_rd), 32'(rd));
            if (chk_wb) check("fwd_data", bus.fwd_data, exp_wb);
        end
    endtask

    task automatic bubble();
        exp_t e;
        @(posedge clk);
        #1;
        bus.agex_valid    = 1'b0;
        bus.agex_is_load  = 1'b0;
        bus.agex_is_store = 1'b0;
        bus.agex_wr_reg   = 1'b1;
        bus.agex_rd       = 5'd6;
        e.cyc    = cyc;
        e.valid  = 1'b0;
        e.wr     = 1'b0;
        e.rd     = '0;
        e.chk_wb = 1'b0;
        e.wb     = '0;
        e.pc     = '0;
        e.ic     = '0;
        sb_q.push_back(e);
        #1;
        check("bubble_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    endtask

    // Monitor: compare the MEM latch against the entry issued before this edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            check("mem_valid", 32'(bus.mem_valid), 32'(e.valid));
            check("mem_wr_reg", 32'(bus.mem_wr_reg), 32'(e.wr));
            if (e.valid) begin
                check("mem_rd", 32'(bus.mem_rd), 32'(e.rd));
                check("mem_pc", bus.mem_pc, e.pc);
                check("mem_inst_count", bus.mem_inst_count, e.ic);
                if (e.chk_wb) check("mem_wb_data", bus.mem_wb_data, e.wb);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset with a valid SW to 0x10 presented: it must not be performed.
        reset               = 1'b1;
        bus.agex_valid      = 1'b1;
        bus.agex_is_load    = 1'b0;
        bus.agex_is_store   = 1'b1;
        bus.agex_funct3     = 3'b010;
        bus.agex_result     = 32'h0000_0010;
        bus.agex_st_data    = 32'hDEAD_BEEF;
        bus.agex_wr_reg     = 1'b0;
        bus.agex_rd         = 5'd0;
        bus.agex_pc         = '0;
        bus.agex_inst_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_mem_wr_reg", 32'(bus.mem_wr_reg), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_wb_data", bus.mem_wb_data, 32'd0);
        check("rst_mem_pc", bus.mem_pc, 32'd0);
        check("rst_mem_inst_count", bus.mem_inst_count, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_misalign_err", 32'(misalign_err), 32'd0);
        check("rst_load_count", load_count, 32'd0);
        check("rst_store_count", store_count, 32'd0);
        // A register-writing ALU op during reset must not forward.
        bus.agex_is_store = 1'b0;
        bus.agex_result   = 32'h0000_0099;
        bus.agex_wr_reg   = 1'b1;
        bus.agex_rd       = 5'd4;
        #1;
        check("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.agex_valid = 1'b0;

        // LW 0x10 after reset: the reset-cycle store was not performed.
        issue(1, 0, 3'b010, 32'h10, 32'h0, 1, 5'd1, 1, 0, 32'h0);
        check_ne("lw_after_reset", bus.fwd_data, 32'hDEAD_BEEF);

        // Byte/half extraction and sign handling.
        issue(0, 1, 3'b010, 32'h40, 32'h1234_5678, 0, 5'd0, 0, 1, 32'h40);
        issue(1, 0, 3'b000, 32'h43, 32'h0, 1, 5'd5, 1, 1, 32'h0000_0012);
        issue(1, 0, 3'b100, 32'h43, 32'h0, 1, 5'd5, 1, 1, 32'h0000_0012);
        issue(1, 0, 3'b001, 32'h42, 32'h0, 1, 5'd5, 1, 1, 32'h0000_1234);
        issue(1, 0, 3'b101, 32'h42, 32'h0, 1, 5'd5, 1, 1, 32'h0000_1234);
        issue(0, 1, 3'b000, 32'h41, 32'h0000_0080, 0, 5'd0, 0, 1, 32'h41);
        issue(1, 0, 3'b000, 32'h41, 32'h0, 1, 5'd5, 1, 1, 32'hFFFF_FF80);
        issue(1, 0, 3'b010, 32'h40, 32'h0, 1, 5'd5, 1, 1, 32'h1234_8078);

        // ALU results pass through; rd=0 never writes.
        issue(0, 0, 3'b000, 32'h55, 32'h0, 1, 5'd3, 1, 1, 32'h55);
        issue(0, 0, 3'b000, 32'h77, 32'h0, 1, 5'd0, 0, 1, 32'h77);

        // MMIO: LED store/load, other MMIO reads as 0, other MMIO stores dropped.
        issue(0, 1, 3'b010, 32'hFFFF_F020, 32'h0000_03FF, 0, 5'd0, 0, 1, 32'hFFFF_F020);
        issue(1, 0, 3'b010, 32'hFFFF_F020, 32'h0, 1, 5'd7, 1, 1, 32'h0000_03FF);
        check("led_after_sw", 32'(led), 32'h3FF);
        issue(1, 0, 3'b010, 32'hFFFF_F004, 32'h0, 1, 5'd8, 1, 1, 32'h0);
        issue(0, 1, 3'b001, 32'hFFFF_F020, 32'h0000_1234, 0, 5'd0, 0, 1, 32'hFFFF_F020);
        issue(1, 0, 3'b000, 32'hFFFF_F020, 32'h0, 1, 5'd9, 1, 1, 32'h0000_0234);
        issue(0, 1, 3'b010, 32'hFFFF_F024, 32'h0000_0005, 0, 5'd0, 0, 1, 32'hFFFF_F024);
        issue(1, 0, 3'b010, 32'hFFFF_F020, 32'h0, 1, 5'd9, 1, 1, 32'h0000_0234);
        bubble();
        check("load_count_a", load_count, 32'd11);
        check("store_count_a", store_count, 32'd5);
        check("misalign_err_a", 32'(misalign_err), 32'd0);

        // Misaligned LW and SH: squashed, flag sticks, counters frozen.
        issue(1, 0, 3'b010, 32'h42, 32'h0, 1, 5'd10, 0, 0, 32'h0);
        issue(0, 1, 3'b001, 32'h41, 32'h0000_BEEF, 0, 5'd0, 0, 1, 32'h41);
        bubble();
        check("misalign_err_b", 32'(misalign_err), 32'd1);
        check("load_count_b", load_count, 32'd11);
        check("store_count_b", store_count, 32'd5);
        issue(1, 0, 3'b010, 32'h40, 32'h0, 1, 5'd11, 1, 1, 32'h1234_8078);

        // Aligned traffic interleaved with bubbles; store with wr_reg=1 stays a store.
        bubble();
        issue(0, 1, 3'b010, 32'h44, 32'hA5A5_0001, 1, 5'd12, 0, 1, 32'h44);
        bubble();
        issue(1, 0, 3'b010, 32'h44, 32'h0, 1, 5'd13, 1, 1, 32'hA5A5_0001);
        bubble();
        issue(1, 0, 3'b001, 32'h46, 32'h0, 1, 5'd14, 1, 1, 32'hFFFF_A5A5);
        issue(0, 1, 3'b000, 32'h47, 32'h0000_007F, 0, 5'd0, 0, 1, 32'h47);
        issue(1, 0, 3'b100, 32'h47, 32'h0, 1, 5'd15, 1, 1, 32'h0000_007F);
        issue(1, 0, 3'b010, 32'h44, 32'h0, 1, 5'd16, 1, 1, 32'h7FA5_0001);
        bubble();
        check("load_count_c", load_count, 32'd16);
        check("store_count_c", store_count, 32'd7);
        check("misalign_err_c", 32'(misalign_err), 32'd1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline, directly downstream of the AGEX stage latch and upstream of WB.
- Performs loads/stores against an internal word-organised data memory and a memory-mapped LED register.
- Registers results into the MEM latch for WB and drives a combinational forwarding path back to DE.

Parameters:
- DBITS, 32, datapath width.
- DMEM_ADDR_BITS, 12, log2 of data memory depth in 32-bit words.
- MMIO_BASE, 32'hFFFFF000, start of the MMIO region; it extends to the top of the address space.
- LED_ADDR, 32'hFFFFF020, LED register address.
- LED_BITS, 10, LED register width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- agex_valid  in  1  AGEX latch holds a real instruction.
- agex_is_load  in  1  instruction is a load.
- agex_is_store  in  1  instruction is a store.
- agex_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- agex_result  in  DBITS  ALU result, or effective address for loads/stores.
- agex_st_data  in  DBITS  store data (rs2).
- agex_wr_reg  in  1  instruction writes rd.
- agex_rd  in  5  destination register.
- agex_pc  in  DBITS  PC, passed through.
- agex_inst_count  in  DBITS  instruction count, passed through.
- mem_valid  out  1  MEM latch valid.
- mem_wr_reg  out  1  WB writes rd.
- mem_rd  out  5  latched rd.
- mem_wb_data  out  DBITS  writeback data.
- mem_pc  out  DBITS  latched PC.
- mem_inst_count  out  DBITS  latched instruction count.
- fwd_valid  out  1  combinational: this-cycle instruction will write fwd_rd.
- fwd_rd  out  5  combinational rd.
- fwd_data  out  DBITS  combinational writeback value.
- led  out  LED_BITS  LED register.
- misalign_err  out  1  sticky misaligned-access flag.
- load_count  out  32  retired load count.
- store_count  out  32  retired store count.

Behaviour:
- Reset: synchronous, priority over all other activity.
  - Clears mem_valid, mem_wr_reg, mem_rd, mem_wb_data, mem_pc, mem_inst_count, led, misalign_err, load_count and store_count to 0.
  - DMEM contents are not reset.
  - A store presented in a reset cycle is not performed.
- Address decode: mmio = agex_result >= MMIO_BASE (unsigned compare). Otherwise DMEM word index = agex_result[DMEM_ADDR_BITS+1:2]; upper address bits are ignored (aliasing).
- Misalignment:
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]!=0.
  - B/BU are never misaligned.
  - A misaligned valid load/store: no memory/LED write, no counter increment, mem_wr_reg=0, fwd_valid=0, misalign_err set (sticky until reset). The instruction still propagates with mem_valid=1.
- DMEM read: combinational in the same cycle.
- DMEM write: at posedge when agex_valid & agex_is_store & aligned & !mmio & !reset.
  - Byte-lane writes: SB writes lane addr[1:0] with st_data[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with st_data[15:0]; SW writes all lanes.
  - Untouched lanes are preserved.
- Load extraction: select byte/half by address.
  - B/H sign-extend; BU/HU zero-extend; W unmodified.
- Store in cycle N followed by a load of the same address in cycle N+1 returns the new data.
- MMIO:
  - Store to LED_ADDR (any size, aligned) sets led <= st_data[LED_BITS-1:0].
  - Load from LED_ADDR returns led zero-extended; the load's size/sign is ignored.
  - Other MMIO loads return 0; other MMIO stores are dropped.
  - MMIO accesses still count in the counters.
- Writeback value = load data for loads, agex_result otherwise.
- fwd_valid = agex_valid & agex_wr_reg & (agex_rd!=0) & !misaligned. fwd_rd = agex_rd. fwd_data = writeback value. fwd_valid is 0 during reset.
- MEM latch: loaded every cycle with latency 1.
  - mem_valid <= agex_valid.
  - mem_wr_reg <= fwd_valid.
  - mem_rd, mem_wb_data, mem_pc and mem_inst_count are latched.
  - Bubbles (agex_valid=0) latch valid=0 and wr_reg=0.
- Counters: load_count and store_count increment by 1 per valid aligned load/store; wrap at 2^32.
- A store with agex_wr_reg=1 is treated as a store only; wr is forced to 0.

Test Plan:
- Reset for 2 cycles with agex_valid=1 SW to 0x10 data 0xDEADBEEF -> all outputs 0; a subsequent LW from 0x10 does not return 0xDEADBEEF (no write occurred).
- SW 0x12345678 to 0x40; next cycle LB rd=5 from 0x43; then LBU from 0x43; then LH from 0x42; then LHU from 0x42 -> mem_wb_data over successive cycles 0x00000012, 0x00000012, 0x00001234, 0x00001234; after SB 0x80 to 0x41, LB from 0x41 = 0xFFFFFF80, LW from 0x40 = 0x12348078.
- ADD result 0x55 with rd=3 -> fwd_valid=1, fwd_rd=3, fwd_data=0x55 in the same cycle; next cycle mem_wr_reg=1, mem_wb_data=0x55. With rd=0 -> fwd_valid=0 and mem_wr_reg=0.
- SW 0x3FF to 0xFFFFF020 -> led=0x3FF next cycle; LW from 0xFFFFF020 returns 0x3FF; LW from 0xFFFFF004 returns 0.
- LW from 0x42, then SH to 0x41 -> misalign_err=1 and stays 1; mem_wr_reg=0; memory unchanged; load_count and store_count unchanged.
- Three aligned loads and two aligned stores interleaved with bubbles -> load_count=3, store_count=2; bubbles produce mem_valid=0.
